// File: rtl/udar_pkg.sv
// udar_pkg: UDAR frame codes, command op codes, result codes and FSM state encoding
package udar_pkg;
  localparam logic [7:0] F_INIT      = 8'h00;
  localparam logic [7:0] F_INIT_ACK  = 8'hAA;
  localparam logic [7:0] F_SERVO     = 8'h03;
  localparam logic [7:0] F_SERVO_ACK = 8'hAB;
  localparam logic [7:0] F_TRIG      = 8'h0C;
  localparam logic [7:0] F_TRIG_ACK  = 8'hAE;
  localparam logic [1:0] OP_INIT         = 2'd0;
  localparam logic [1:0] OP_MOVE         = 2'd1;
  localparam logic [1:0] OP_MEASURE      = 2'd2;
  localparam logic [1:0] OP_MOVE_MEASURE = 2'd3;
  localparam logic [1:0] ERR_OK      = 2'd0;
  localparam logic [1:0] ERR_TIMEOUT = 2'd1;
  localparam logic [1:0] ERR_BADACK  = 2'd2;
  localparam logic [2:0] ST_IDLE       = 3'd0;
  localparam logic [2:0] ST_TX_REQ     = 3'd1;
  localparam logic [2:0] ST_TX_WAIT_HI = 3'd2;
  localparam logic [2:0] ST_TX_WAIT_LO = 3'd3;
  localparam logic [2:0] ST_RX_ACK     = 3'd4;
  localparam logic [2:0] ST_RX_HI      = 3'd5;
  localparam logic [2:0] ST_RX_LO      = 3'd6;
  localparam logic [2:0] ST_DONE       = 3'd7;
  function automatic logic [7:0] ack_of(input logic [1:0] op);
    return op == OP_INIT ? F_INIT_ACK : op == OP_MEASURE ? F_TRIG_ACK : F_SERVO_ACK;
  endfunction
  function automatic logic [1:0] first_op(input logic [1:0] op);
    return op == OP_MOVE_MEASURE ? OP_MOVE : op;
  endfunction
endpackage

// File: rtl/udar_host_tx_byte_hs.sv
// tx_byte_hs: one-byte UART transmit handshake (request, busy rise, busy fall) with wait timeout
module tx_byte_hs
  import udar_pkg::*;
#(
  parameter int RESP_TIMEOUT = 5000000,
  parameter int TO_LEN       = 24
) (
  input  logic       clk,
  input  logic       rst_i,
  input  logic       i_go,
  input  logic [7:0] i_byte,
  input  logic       i_tx_busy,
  output logic [7:0] o_tx_byte,
  output logic       o_tx_send,
  output logic       o_done,
  output logic       o_timeout
);
  localparam logic [TO_LEN-1:0] TO_LIM = TO_LEN'(RESP_TIMEOUT - 1);
  logic [2:0]        r_ph;
  logic [TO_LEN-1:0] r_cnt;
  logic [7:0]        r_byte;
  logic              r_send;
  logic              w_wait, w_met, w_send;
  assign w_wait    = r_ph == ST_TX_WAIT_HI || r_ph == ST_TX_WAIT_LO;
  assign w_met     = r_ph == ST_TX_WAIT_HI ? i_tx_busy : !i_tx_busy;
  assign w_send    = r_ph == ST_TX_REQ && i_go && !i_tx_busy;
  assign o_done    = r_ph == ST_TX_WAIT_LO && !i_tx_busy;
  assign o_timeout = w_wait && !w_met && r_cnt == TO_LIM;
  assign o_tx_byte = r_byte;
  assign o_tx_send = r_send;
  // a satisfied wait condition in the expiry cycle takes priority over the timeout
  always_ff @(posedge clk or posedge rst_i)
    if (rst_i) begin
      r_ph   <= ST_TX_REQ;
      r_cnt  <= '0;
      r_byte <= '0;
      r_send <= 1'b0;
    end else begin
      r_send <= w_send;
      if (w_send) r_byte <= i_byte;
      r_cnt <= w_wait && !w_met ? r_cnt + 1'b1 : '0;
      r_ph  <= w_send ? ST_TX_WAIT_HI :
               o_done || o_timeout ? ST_TX_REQ :
               w_wait && w_met ? ST_TX_WAIT_LO : r_ph;
    end
endmodule

// File: rtl/udar_host.sv
// udar_host: UDAR protocol host initiator, frames commands and parses ack/distance replies
// Define UDAR_HOST_RETRY_EN to re-run a failed command up to MAX_RETRY more times.
module udar_host
  import udar_pkg::*;
#(
  parameter int RESP_TIMEOUT = 5000000,
  parameter int TO_LEN       = 24,
  parameter int POS_LEN      = 8,
  parameter int DIST_LEN     = 16,
  parameter int MAX_RETRY    = 3
) (
  input  logic                clk,
  input  logic                rst_i,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [1:0]          cmd_op,
  input  logic [POS_LEN-1:0]  cmd_x,
  input  logic [POS_LEN-1:0]  cmd_y,
  output logic [7:0]          tx_byte,
  output logic                tx_send,
  input  logic                tx_busy,
  input  logic [7:0]          rx_byte,
  input  logic                rx_valid,
  output logic                res_valid,
  output logic [1:0]          res_err,
  output logic [DIST_LEN-1:0] res_dist,
  output logic                busy
);
  localparam logic [TO_LEN-1:0] TO_LIM = TO_LEN'(RESP_TIMEOUT - 1);
  if (RESP_TIMEOUT < 2 || RESP_TIMEOUT > 2 ** TO_LEN || MAX_RETRY < 0) begin : g_bad_cfg
    $error("udar_host: RESP_TIMEOUT must fit TO_LEN and MAX_RETRY must be non-negative");
  end
  logic [2:0]          r_st;
  logic [1:0]          r_op, r_cur, r_err, r_idx;
  logic [POS_LEN-1:0]  r_x, r_y;
  logic [7:0]          r_hi;
  logic [DIST_LEN-1:0] r_dist;
  logic [TO_LEN-1:0]   r_cnt;
  logic                w_rx_st, w_last, w_go, w_tx_done, w_tx_to, w_fail;
  logic [7:0]          w_byte;
  logic [1:0]          w_ferr;
`ifdef UDAR_HOST_RETRY_EN
  localparam int RW = MAX_RETRY > 1 ? $clog2(MAX_RETRY + 1) : 1;
  localparam logic [RW-1:0] RETRY_LIM = RW'(MAX_RETRY);
  logic [RW-1:0] r_retry;
`endif
  assign cmd_ready = r_st == ST_IDLE;
  assign busy      = !cmd_ready;
  assign res_valid = r_st == ST_DONE;
  assign res_err   = r_err;
  assign res_dist  = r_dist;
  assign w_go      = r_st == ST_TX_REQ;
  assign w_rx_st   = r_st inside {ST_RX_ACK, ST_RX_HI, ST_RX_LO};
  // r_cur is the sub-command on the wire: MOVE_MEASURE runs as MOVE then MEASURE
  assign w_byte = r_cur == OP_INIT ? F_INIT : r_cur == OP_MEASURE ? F_TRIG :
                  r_idx == 2'd0 ? F_SERVO : r_idx == 2'd1 ? 8'(r_x) : 8'(r_y);
  assign w_last = r_cur != OP_MOVE || r_idx == 2'd2;
  assign w_fail = (w_go && w_tx_to) ||
                  (w_rx_st && !rx_valid && r_cnt == TO_LIM) ||
                  (r_st == ST_RX_ACK && rx_valid && rx_byte != ack_of(r_cur));
  assign w_ferr = r_st == ST_RX_ACK && rx_valid ? ERR_BADACK : ERR_TIMEOUT;
  tx_byte_hs #(
    .RESP_TIMEOUT(RESP_TIMEOUT),
    .TO_LEN      (TO_LEN)
  ) u_tx (
    .clk      (clk),
    .rst_i    (rst_i),
    .i_go     (w_go),
    .i_byte   (w_byte),
    .i_tx_busy(tx_busy),
    .o_tx_byte(tx_byte),
    .o_tx_send(tx_send),
    .o_done   (w_tx_done),
    .o_timeout(w_tx_to)
  );
  always_ff @(posedge clk or posedge rst_i)
    if (rst_i) begin
      r_st   <= ST_IDLE;
      r_op   <= '0;
      r_cur  <= '0;
      r_x    <= '0;
      r_y    <= '0;
      r_idx  <= '0;
      r_hi   <= '0;
      r_dist <= '0;
      r_cnt  <= '0;
      r_err  <= '0;
`ifdef UDAR_HOST_RETRY_EN
      r_retry <= '0;
`endif
    end else begin
      r_cnt <= w_rx_st && !rx_valid ? r_cnt + 1'b1 : '0;
      if (w_fail) begin
`ifdef UDAR_HOST_RETRY_EN
        if (r_retry != RETRY_LIM) begin
          r_retry <= r_retry + 1'b1;
          r_cur   <= first_op(r_op);
          r_idx   <= '0;
          r_st    <= ST_TX_REQ;
        end else begin
          r_err <= w_ferr;
          r_st  <= ST_DONE;
        end
`else
        r_err <= w_ferr;
        r_st  <= ST_DONE;
`endif
      end else begin
        case (r_st)
          ST_IDLE: if (cmd_valid) begin
            r_op  <= cmd_op;
            r_cur <= first_op(cmd_op);
            r_x   <= cmd_x;
            r_y   <= cmd_y;
            r_idx <= '0;
            r_err <= ERR_OK;
`ifdef UDAR_HOST_RETRY_EN
            r_retry <= '0;
`endif
            r_st  <= ST_TX_REQ;
          end
          ST_TX_REQ: if (w_tx_done) begin
            r_idx <= w_last ? '0 : r_idx + 1'b1;
            r_st  <= w_last ? ST_RX_ACK : ST_TX_REQ;
          end
          ST_RX_ACK: if (rx_valid) begin
            if (r_cur == OP_MEASURE) r_st <= ST_RX_HI;
            else if (r_op == OP_MOVE_MEASURE) begin
              r_cur <= OP_MEASURE;
              r_st  <= ST_TX_REQ;
            end else r_st <= ST_DONE;
          end
          ST_RX_HI: if (rx_valid) begin
            r_hi <= rx_byte;
            r_st <= ST_RX_LO;
          end
          ST_RX_LO: if (rx_valid) begin
            r_dist <= DIST_LEN'({r_hi, rx_byte});
            r_st   <= ST_DONE;
          end
          default: r_st <= ST_IDLE;
        endcase
      end
    end
endmodule

// File: tb/tb_udar_host.sv
// tb_udar_host: directed bench for udar_host with a busy-stretching UART transmitter model
module tb_udar_host;
  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [7:0]  cmd_x, cmd_y;
  logic [7:0]  tx_byte;
  logic        tx_send;
  logic        tx_busy;
  logic [7:0]  rx_byte;
  logic        rx_valid = 1'b0;
  logic        res_valid;
  logic [1:0]  res_err;
  logic [15:0] res_dist;
  logic        busy;
  int checks = 0, failures = 0, nres = 0, bcnt = 0, n, n0;
  logic [7:0] cap[$];

  always #5 clk = ~clk;

  udar_host #(.RESP_TIMEOUT(100)) dut (
    .clk(clk), .rst_i(rst_i), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_x(cmd_x), .cmd_y(cmd_y), .tx_byte(tx_byte),
    .tx_send(tx_send), .tx_busy(tx_busy), .rx_byte(rx_byte), .rx_valid(rx_valid),
    .res_valid(res_valid), .res_err(res_err), .res_dist(res_dist), .busy(busy)
  );

  always @(posedge clk) begin
    if (tx_send) begin
      cap.push_back(tx_byte);
      bcnt <= 3;
    end else if (bcnt != 0) bcnt <= bcnt - 1;
    if (res_valid === 1'b1) nres++;
  end
  assign tx_busy = bcnt != 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [1:0] op, input logic [7:0] x, input logic [7:0] y);
    cap.delete();
    cmd_op = op;
    cmd_x = x;
    cmd_y = y;
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_tx(input int cnt);
    for (int i = 0; i < 300 && !(cap.size() == cnt && !tx_busy); i++) @(negedge clk);
    chk("tx_count", cap.size(), cnt);
    @(negedge clk);
  endtask

  task automatic send_rx(input logic [7:0] b);
    rx_byte = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic wait_res(input int lim, output int cyc);
    cyc = 0;
    while (res_valid !== 1'b1 && cyc < lim) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    cmd_op = 2'd0;
    cmd_x = 8'h00;
    cmd_y = 8'h00;
    rx_byte = 8'h00;
    repeat (2) @(negedge clk);
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_tx_send", tx_send, 0);
    chk("rst_tx_byte", tx_byte, 8'h00);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_res_err", res_err, 0);
    chk("rst_res_dist", res_dist, 16'h0000);
    rst_i = 1'b0;
    @(negedge clk);

    issue(2'd0, 8'h00, 8'h00);
    chk("init_busy", busy, 1);
    wait_tx(1);
    chk("init_tx0", cap[0], 8'h00);
    send_rx(8'hAA);
    chk("init_rv", res_valid, 1);
    chk("init_err", res_err, 0);
    chk("init_dist", res_dist, 16'h0000);
    @(negedge clk);
    chk("init_pulse", res_valid, 0);
    chk("init_ready", cmd_ready, 1);

    issue(2'd2, 8'h00, 8'h00);
    wait_tx(1);
    chk("meas_tx0", cap[0], 8'h0C);
    send_rx(8'hAE);
    send_rx(8'h12);
    chk("meas_early", res_valid, 0);
    send_rx(8'h34);
    chk("meas_rv", res_valid, 1);
    chk("meas_err", res_err, 0);
    chk("meas_dist", res_dist, 16'h1234);
    @(negedge clk);

    n0 = nres;
    issue(2'd3, 8'h50, 8'hA0);
    wait_tx(3);
    chk("mm_tx0", cap[0], 8'h03);
    chk("mm_tx1", cap[1], 8'h50);
    chk("mm_tx2", cap[2], 8'hA0);
    send_rx(8'hAB);
    chk("mm_mid_rv", res_valid, 0);
    wait_tx(4);
    chk("mm_tx3", cap[3], 8'h0C);
    send_rx(8'hAE);
    send_rx(8'h00);
    send_rx(8'h7F);
    chk("mm_rv", res_valid, 1);
    chk("mm_err", res_err, 0);
    chk("mm_dist", res_dist, 16'h007F);
    repeat (2) @(negedge clk);
    chk("mm_one_result", nres, n0 + 1);

    issue(2'd1, 8'h11, 8'h22);
`ifdef UDAR_HOST_RETRY_EN
    for (int a = 0; a < 4; a++) begin
      wait_tx(3 * (a + 1));
      send_rx(8'hAA);
      if (a < 3) chk("retry_rv", res_valid, 0);
    end
    chk("retry_tx9", cap[9], 8'h03);
    chk("retry_tx10", cap[10], 8'h11);
    chk("retry_tx11", cap[11], 8'h22);
`else
    wait_tx(3);
    send_rx(8'hAA);
`endif
    chk("bad_tx0", cap[0], 8'h03);
    chk("bad_tx1", cap[1], 8'h11);
    chk("bad_tx2", cap[2], 8'h22);
    chk("bad_rv", res_valid, 1);
    chk("bad_err", res_err, 2);
    chk("bad_dist", res_dist, 16'h007F);
    @(negedge clk);

    issue(2'd0, 8'h00, 8'h00);
    wait_tx(1);
    wait_res(3000, n);
`ifdef UDAR_HOST_RETRY_EN
    chk("to_attempts", cap.size(), 4);
`else
    chk("to_cycles", n, 100);
`endif
    chk("to_rv", res_valid, 1);
    chk("to_err", res_err, 1);
    chk("to_dist", res_dist, 16'h007F);
    @(negedge clk);

    issue(2'd0, 8'h00, 8'h00);
    wait_tx(1);
    repeat (99) @(negedge clk);
    chk("to99_pre", res_valid, 0);
    send_rx(8'hAA);
    chk("to99_rv", res_valid, 1);
    chk("to99_err", res_err, 0);
    @(negedge clk);

    issue(2'd1, 8'h33, 8'h44);
    for (int i = 0; i < 300 && cap.size() != 3; i++) @(negedge clk);
    chk("rst_mid_count", cap.size(), 3);
    @(negedge clk);
    n0 = nres;
    rst_i = 1'b1;
    #1;
    chk("rst_mid_send", tx_send, 0);
    chk("rst_mid_ready", cmd_ready, 1);
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_rv", res_valid, 0);
    chk("rst_mid_dist", res_dist, 16'h0000);
    repeat (3) @(negedge clk);
    rst_i = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_mid_nores", nres, n0);
    send_rx(8'hAB);
    chk("stray_rv", res_valid, 0);
    chk("stray_ready", cmd_ready, 1);
    chk("stray_err", res_err, 0);
    chk("stray_dist", res_dist, 16'h0000);
    @(negedge clk);
    chk("stray_nores", nres, n0);

    issue(2'd0, 8'h00, 8'h00);
    wait_tx(1);
    chk("post_tx0", cap[0], 8'h00);
    send_rx(8'hAA);
    chk("post_rv", res_valid, 1);
    chk("post_err", res_err, 0);
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
